ws2812_rx: RTL and testbench

WS2812_RX -- requirements
Module: ws2812_rx

---
 rtl/ws2812_rx.sv | 183 ++++++++++++++++++
 tb/tb_ws2812_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// WS2812 line decoder: pulse-width classifies bits, assembles 24-bit GRB pixels, tracks frames.
// Latency: pixel_valid 3 clk edges after the line falls on bit 23; no backpressure, input is free-running.
module ws2812_rx #(
    parameter int THRESH    = 30,
    parameter int MIN_HIGH  = 8,
    parameter int MAX_HIGH  = 100,
    parameter int RESET_CYC = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [15:0] pixel_index,
    output logic        frame_end,
    output logic [15:0] frame_len,
    output logic        err,
    output logic        busy
);

    localparam logic [15:0] L_THRESH = 16'(THRESH);
    localparam logic [15:0] L_MIN    = 16'(MIN_HIGH);
    localparam logic [15:0] L_MAX    = 16'(MAX_HIGH);
    localparam logic [15:0] L_RESET  = 16'(RESET_CYC);

    typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_sync1, r_ds;
    logic [15:0] r_high_cnt, w_high_nxt, w_high_inc;
    logic [15:0] r_low_cnt, w_low_nxt, w_low_inc;
    logic [23:0] r_shift, w_shift_nxt, w_shifted;
    logic [4:0]  r_bit_cnt, w_bit_nxt;
    logic [15:0] r_pix_cnt, w_pix_nxt;
    logic [23:0] r_pixel_data, w_pdata_nxt;
    logic [15:0] r_pixel_index, w_pidx_nxt;
    logic [15:0] r_frame_len, w_flen_nxt;
    logic        r_pixel_valid, r_frame_end, r_err;
    logic        w_pvld, w_fend, w_err, w_abort, w_bit;

    always_comb begin
        w_state_nxt = r_state;
        w_high_nxt  = r_high_cnt;
        w_low_nxt   = r_low_cnt;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_pix_nxt   = r_pix_cnt;
        w_pdata_nxt = r_pixel_data;
        w_pidx_nxt  = r_pixel_index;
        w_flen_nxt  = r_frame_len;
        w_pvld      = 1'b0;
        w_fend      = 1'b0;
        w_err       = 1'b0;
        w_abort     = 1'b0;
        w_high_inc  = (r_high_cnt == 16'hFFFF) ? r_high_cnt : r_high_cnt + 16'd1;
        w_low_inc   = (r_low_cnt == 16'hFFFF) ? r_low_cnt : r_low_cnt + 16'd1;
        w_bit       = (r_high_cnt >= L_THRESH);
        w_shifted   = {r_shift[22:0], w_bit};

        case (r_state)
            S_SYNC: begin
                if (r_ds) begin
                    w_low_nxt = 16'd0;
                end else if (w_low_inc >= L_RESET) begin
                    w_state_nxt = S_IDLE;
                    w_low_nxt   = 16'd0;
                end else begin
                    w_low_nxt = w_low_inc;
                end
            end
            S_IDLE: begin
                if (r_ds) begin
                    w_state_nxt = S_HIGH;
                    w_high_nxt  = 16'd1;
                end
            end
            S_HIGH: begin
                if (r_ds) begin
                    if (w_high_inc > L_MAX) begin
                        w_err   = 1'b1;
                        w_abort = 1'b1;
                    end else begin
                        w_high_nxt = w_high_inc;
                    end
                end else if (r_high_cnt < L_MIN) begin
                    w_err   = 1'b1;
                    w_abort = 1'b1;
                end else begin
                    w_state_nxt = S_LOW;
                    w_low_nxt   = 16'd1;
                    w_high_nxt  = 16'd0;
                    if (r_bit_cnt == 5'd23) begin
                        w_pvld      = 1'b1;
                        w_pdata_nxt = w_shifted;
                        w_pidx_nxt  = r_pix_cnt;
                        w_pix_nxt   = (r_pix_cnt == 16'hFFFF) ? r_pix_cnt : r_pix_cnt + 16'd1;
                        w_bit_nxt   = 5'd0;
                        w_shift_nxt = 24'd0;
                    end else begin
                        w_shift_nxt = w_shifted;
                        w_bit_nxt   = r_bit_cnt + 5'd1;
                    end
                end
            end
            S_LOW: begin
                if (r_ds) begin
                    w_state_nxt = S_HIGH;
                    w_high_nxt  = 16'd1;
                end else if (w_low_inc >= L_RESET) begin
                    w_state_nxt = S_IDLE;
                    w_low_nxt   = 16'd0;
                    if (r_pix_cnt != 16'd0) begin
                        w_fend     = 1'b1;
                        w_flen_nxt = r_pix_cnt;
                        w_pix_nxt  = 16'd0;
                    end
                    // A latch mid-pixel drops the stray bits but still closes the frame.
                    if (r_bit_cnt != 5'd0) begin
                        w_err       = 1'b1;
                        w_bit_nxt   = 5'd0;
                        w_shift_nxt = 24'd0;
                    end
                end else begin
                    w_low_nxt = w_low_inc;
                end
            end
            default: w_state_nxt = S_SYNC;
        endcase

        // Protocol errors abandon the frame; resync needs a full reset gap.
        if (w_abort) begin
            w_state_nxt = S_SYNC;
            w_high_nxt  = 16'd0;
            w_low_nxt   = 16'd0;
            w_bit_nxt   = 5'd0;
            w_shift_nxt = 24'd0;
            w_pix_nxt   = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_SYNC;
            r_sync1       <= 1'b0;
            r_ds          <= 1'b0;
            r_high_cnt    <= 16'd0;
            r_low_cnt     <= 16'd0;
            r_shift       <= 24'd0;
            r_bit_cnt     <= 5'd0;
            r_pix_cnt     <= 16'd0;
            r_pixel_data  <= 24'd0;
            r_pixel_index <= 16'd0;
            r_frame_len   <= 16'd0;
            r_pixel_valid <= 1'b0;
            r_frame_end   <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sync1       <= din;
            r_ds          <= r_sync1;
            r_high_cnt    <= w_high_nxt;
            r_low_cnt     <= w_low_nxt;
            r_shift       <= w_shift_nxt;
            r_bit_cnt     <= w_bit_nxt;
            r_pix_cnt     <= w_pix_nxt;
            r_pixel_data  <= w_pdata_nxt;
            r_pixel_index <= w_pidx_nxt;
            r_frame_len   <= w_flen_nxt;
            r_pixel_valid <= w_pvld;
            r_frame_end   <= w_fend;
            r_err         <= w_err;
        end
    end

    assign pixel_data  = r_pixel_data;
    assign pixel_valid = r_pixel_valid;
    assign pixel_index = r_pixel_index;
    assign frame_end   = r_frame_end;
    assign frame_len   = r_frame_len;
    assign err         = r_err;
    assign busy        = (r_state == S_HIGH) || (r_state == S_LOW);

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: line waveforms driven on negedge, outputs sampled on negedge.
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [15:0] pixel_index;
    logic        frame_end;
    logic [15:0] frame_len;
    logic        err;
    logic        busy;

    ws2812_rx dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .pixel_data (pixel_data),
        .pixel_valid(pixel_valid),
        .pixel_index(pixel_index),
        .frame_end  (frame_end),
        .frame_len  (frame_len),
        .err        (err),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [23:0] data;
        logic [15:0] idx;
    } pix_t;

    pix_t        exp_pix[$];
    logic [15:0] exp_flen[$];
    bit          exp_err[$];
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          last_fall = 0;
    int          last_lo   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drain(input string tag);
        check({tag, "_pix_q"}, exp_pix.size(), 0);
        check({tag, "_flen_q"}, exp_flen.size(), 0);
        check({tag, "_err_q"}, exp_err.size(), 0);
    endtask

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    // MSB-first bits of d, starting at bit 23; each bit is high h then low per-h.
    task automatic send_bits(input logic [23:0] d, input int nbits, input int hi1, input int hi0, input int per);
        for (int i = 23; i >= 24 - nbits; i--) begin
            int h;
            h = d[i] ? hi1 : hi0;
            hold(1'b1, h);
            last_fall = cyc;
            last_lo   = per - h;
            hold(1'b0, per - h);
        end
    endtask

    task automatic px(input logic [23:0] d, input logic [15:0] idx);
        pix_t e;
        e.data = d;
        e.idx  = idx;
        exp_pix.push_back(e);
        send_bits(d, 24, 40, 20, 62);
    endtask

    always @(negedge clk) begin
        pix_t e;
        logic [15:0] fl;
        bit eb;
        if (!rst) begin
            if (pixel_valid) begin
                if (exp_pix.size() == 0) begin
                    check("pix_unexpected", 32'(pixel_data), 32'hFFFFFFFF);
                end else begin
                    e = exp_pix.pop_front();
                    check("pix_data", 32'(pixel_data), 32'(e.data));
                    check("pix_index", 32'(pixel_index), 32'(e.idx));
                    check("pix_latency", cyc - last_fall, 3);
                end
            end
            if (frame_end) begin
                if (exp_flen.size() == 0) begin
                    check("fend_unexpected", 32'(frame_len), 32'hFFFFFFFF);
                end else begin
                    fl = exp_flen.pop_front();
                    check("frame_len", 32'(frame_len), 32'(fl));
                end
            end
            if (err) begin
                if (exp_err.size() == 0) begin
                    check("err_unexpected", 1, 0);
                end else begin
                    eb = exp_err.pop_front();
                    check("err_pulse", 32'(err), 32'(eb));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        din = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_pixel_data", 32'(pixel_data), 0);
        check("rst_pixel_valid", 32'(pixel_valid), 0);
        check("rst_pixel_index", 32'(pixel_index), 0);
        check("rst_frame_end", 32'(frame_end), 0);
        check("rst_frame_len", 32'(frame_len), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        hold(1'b0, 2510);
        check("idle_busy", 32'(busy), 0);

        // Single pixel, then latch
        px(24'hA5C30F, 16'd0);
        check("busy_in_frame", 32'(busy), 1);
        exp_flen.push_back(16'd1);
        hold(1'b0, 2600);
        check("busy_after_latch", 32'(busy), 0);
        check("pixel_data_hold", 32'(pixel_data), 32'h00A5C30F);
        drain("t_single");

        // Three-pixel frame
        px(24'h000001, 16'd0);
        px(24'hFFFFFF, 16'd1);
        px(24'h800000, 16'd2);
        exp_flen.push_back(16'd3);
        hold(1'b0, 2600);
        drain("t_three");

        // Reset mid-frame, released with the line high: nothing decodes until a full gap
        send_bits(24'hFFFFFF, 10, 40, 20, 62);
        din = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_pixel_data", 32'(pixel_data), 0);
        check("midrst_frame_len", 32'(frame_len), 0);
        check("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        hold(1'b1, 30);
        send_bits(24'h123456, 24, 40, 20, 62);
        check("nosync_busy", 32'(busy), 0);
        hold(1'b0, 2600);
        drain("t_nosync");
        px(24'h654321, 16'd0);
        exp_flen.push_back(16'd1);
        hold(1'b0, 2600);
        drain("t_resync");

        // Glitch after bit 10
        send_bits(24'hABCDEF, 10, 40, 20, 62);
        check("glitch_busy_before", 32'(busy), 1);
        exp_err.push_back(1'b1);
        hold(1'b1, 5);
        hold(1'b0, 10);
        check("glitch_busy_after", 32'(busy), 0);
        send_bits(24'h0F0F0F, 14, 40, 20, 62);
        check("glitch_busy_rest", 32'(busy), 0);
        hold(1'b0, 2600);
        drain("t_glitch");
        px(24'h0F0F0F, 16'd0);
        exp_flen.push_back(16'd1);
        hold(1'b0, 2600);
        drain("t_glitch_recover");

        // Partial pixel at latch, then stuck-high
        send_bits(24'hC0FFEE, 12, 40, 20, 62);
        exp_err.push_back(1'b1);
        hold(1'b0, 2600);
        check("partial_frame_len_hold", 32'(frame_len), 1);
        drain("t_partial");
        exp_err.push_back(1'b1);
        hold(1'b1, 101);
        hold(1'b0, 5);
        check("stuck_busy", 32'(busy), 0);
        drain("t_stuck");
        hold(1'b0, 2600);

        // Threshold 29/30, gap 2499 continues, gap 2500 latches
        begin
            pix_t e;
            e.data = 24'h5AA55A;
            e.idx  = 16'd0;
            exp_pix.push_back(e);
            send_bits(24'h5AA55A, 24, 30, 29, 62);
        end
        hold(1'b0, 2499 - last_lo);
        px(24'h3C3C3C, 16'd1);
        exp_flen.push_back(16'd2);
        hold(1'b0, 2500 - last_lo);
        px(24'h112233, 16'd0);
        exp_flen.push_back(16'd1);
        hold(1'b0, 2600);
        drain("t_boundary");

        // Shortest legal and longest legal high pulses
        begin
            pix_t e;
            e.data = 24'h00FF00;
            e.idx  = 16'd0;
            exp_pix.push_back(e);
            send_bits(24'h00FF00, 24, 100, 8, 130);
        end
        exp_flen.push_back(16'd1);
        hold(1'b0, 2600);
        drain("t_extremes");
        check("final_frame_len", 32'(frame_len), 1);
        check("final_pixel_data", 32'(pixel_data), 32'h0000FF00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
